universal_reg: RTL and testbench

- Parametrised multi-mode register, the next generation of the team's single-bit storage elements.
- Edge-triggered on clk rather than level-sensitive.
- Supports the following modes, selected per cycle:
  - hold
  - parallel load (D-type)
  - masked toggle (T-type)
  - logical shift left/right with serial fill
  - rotate left/right
  - synchronous clear
- Used as the general storage/shift primitive in datapaths and serial front-ends.

---
 rtl/universal_reg_pkg.sv | 18 +
 rtl/universal_reg_next.sv | 52 +++++
 rtl/universal_reg.sv | 72 +++++++
 tb/tb_universal_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/universal_reg_pkg.sv
// Shared types for the universal_reg multi-mode register.
// Mode encodings used by the top and its next-state logic.
package universal_reg_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_TGL  = 3'b010,
      MODE_SHL  = 3'b011,
      MODE_SHR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_ROR  = 3'b110,
      MODE_CLR  = 3'b111
   } mode_e;

endpackage

// File: rtl/universal_reg_next.sv
// Combinational next-state logic for universal_reg.
// shift_op marks modes that produce a new serial output bit.
module universal_reg_next
   import universal_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic [WIDTH-1:0]  q,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic [WIDTH-1:0]  t_mask,
   input  logic              ser_in,
   output logic [WIDTH-1:0]  next_q,
   output logic              next_ser_out,
   output logic              shift_op
);

   always_comb begin
      next_q       = q;
      next_ser_out = 1'b0;
      shift_op     = 1'b0;
      unique case (mode_e'(mode))
         MODE_HOLD: next_q = q;
         MODE_LOAD: next_q = d;
         MODE_TGL:  next_q = q ^ t_mask;
         MODE_SHL: begin
            next_q       = {q[WIDTH-2:0], ser_in};
            next_ser_out = q[WIDTH-1];
            shift_op     = 1'b1;
         end
         MODE_SHR: begin
            next_q       = {ser_in, q[WIDTH-1:1]};
            next_ser_out = q[0];
            shift_op     = 1'b1;
         end
         MODE_ROL: begin
            next_q       = {q[WIDTH-2:0], q[WIDTH-1]};
            next_ser_out = q[WIDTH-1];
            shift_op     = 1'b1;
         end
         MODE_ROR: begin
            next_q       = {q[0], q[WIDTH-1:1]};
            next_ser_out = q[0];
            shift_op     = 1'b1;
         end
         MODE_CLR:  next_q = RESET_VAL;
         default:   next_q = q;
      endcase
   end

endmodule

// File: rtl/universal_reg.sv
// Multi-mode register: hold/load/toggle/shift/rotate/clear.
// Optional registered even-parity output under UREG_PARITY_EN.
module universal_reg
   import universal_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic [WIDTH-1:0]  t_mask,
   input  logic              ser_in,
   output logic [WIDTH-1:0]  q,
   output logic              ser_out,
   output logic              zero,
   output logic              changed
`ifdef UREG_PARITY_EN
   ,
   output logic              parity
`endif
);

   logic [WIDTH-1:0] nq;
   logic             nso;
   logic             shift_op;
   logic [WIDTH-1:0] q_n;

   universal_reg_next #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_next (
      .q            (q),
      .mode         (mode),
      .d            (d),
      .t_mask       (t_mask),
      .ser_in       (ser_in),
      .next_q       (nq),
      .next_ser_out (nso),
      .shift_op     (shift_op)
   );

   // en=0 collapses every mode to hold
   assign q_n = en ? nq : q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= RESET_VAL;
         ser_out <= 1'b0;
         zero    <= (RESET_VAL == '0);
         changed <= 1'b0;
      end else begin
         q       <= q_n;
         if (en && shift_op)
            ser_out <= nso;
         zero    <= (q_n == '0);
         changed <= en && (q_n != q);
      end
   end

`ifdef UREG_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         parity <= ^RESET_VAL;
      else
         parity <= ^q_n;
   end
`endif

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg (WIDTH=8, RESET_VAL=8'hA5).
// Build with UREG_PARITY_EN to also check the parity output.
module tb_universal_reg;
   import universal_reg_pkg::*;

   localparam int W = 8;
   localparam logic [W-1:0] RV = 8'hA5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic [W-1:0] t_mask;
   logic         ser_in;
   logic [W-1:0] q;
   logic         ser_out;
   logic         zero;
   logic         changed;
`ifdef UREG_PARITY_EN
   logic         parity;
`endif

   typedef struct {
      logic [W-1:0] q;
      logic         so;
      logic         z;
      logic         ch;
      logic         par;
      string        name;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   universal_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .d       (d),
      .t_mask  (t_mask),
      .ser_in  (ser_in),
      .q       (q),
      .ser_out (ser_out),
      .zero    (zero),
      .changed (changed)
`ifdef UREG_PARITY_EN
      ,
      .parity  (parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // monitor: every clock edge with a pending expectation is checked
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.name, ".q"}, 32'(q), 32'(e.q));
         chk({e.name, ".ser_out"}, 32'(ser_out), 32'(e.so));
         chk({e.name, ".zero"}, 32'(zero), 32'(e.z));
         chk({e.name, ".changed"}, 32'(changed), 32'(e.ch));
`ifdef UREG_PARITY_EN
         chk({e.name, ".parity"}, 32'(parity), 32'(e.par));
`endif
      end
   end

   task automatic step(input string nm, input logic e_in,
                       input logic [2:0] m, input logic [W-1:0] dv,
                       input logic [W-1:0] tm, input logic si,
                       input logic [W-1:0] eq, input logic eso,
                       input logic ech);
      exp_t x;
      @(negedge clk);
      en = e_in;
      mode = m;
      d = dv;
      t_mask = tm;
      ser_in = si;
      x.q = eq;
      x.so = eso;
      x.z = (eq == '0);
      x.ch = ech;
      x.par = ^eq;
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   logic [7:0] rol_q [8];
   logic       rol_so [8];

   initial begin
      rol_q  = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
      rol_so = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      rst_n = 1'b0;
      en = 1'b0;
      mode = MODE_HOLD;
      d = '0;
      t_mask = '0;
      ser_in = 1'b0;
      #12;
      chk("rst.q", 32'(q), 32'(RV));
      chk("rst.ser_out", 32'(ser_out), 32'd0);
      chk("rst.zero", 32'(zero), 32'd0);
      chk("rst.changed", 32'(changed), 32'd0);
`ifdef UREG_PARITY_EN
      chk("rst.parity", 32'(parity), 32'(^RV));
`endif
      @(negedge clk);
      rst_n = 1'b1;

      step("load3c", 1, MODE_LOAD, 8'h3C, 8'h00, 0, 8'h3C, 0, 1);
      step("tglff", 1, MODE_TGL, 8'h00, 8'hFF, 0, 8'hC3, 0, 1);
      step("tgl00", 1, MODE_TGL, 8'h00, 8'h00, 0, 8'hC3, 0, 0);
      step("load81", 1, MODE_LOAD, 8'h81, 8'h00, 0, 8'h81, 0, 1);
      step("shl1", 1, MODE_SHL, 8'h00, 8'h00, 1, 8'h03, 1, 1);
      step("shr0", 1, MODE_SHR, 8'h00, 8'h00, 0, 8'h01, 1, 1);
      step("load96", 1, MODE_LOAD, 8'h96, 8'h00, 0, 8'h96, 1, 1);
      for (int i = 0; i < 8; i++)
         step($sformatf("rol%0d", i), 1, MODE_ROL, 8'h00, 8'h00, 0,
              rol_q[i], rol_so[i], 1);
      step("en0", 0, MODE_LOAD, 8'hFF, 8'h00, 0, 8'h96, 0, 0);
      step("clr", 1, MODE_CLR, 8'h00, 8'h00, 0, RV, 0, 1);
      step("loadff", 1, MODE_LOAD, 8'hFF, 8'h00, 0, 8'hFF, 0, 1);
      for (int i = 0; i < 8; i++)
         step($sformatf("shl0_%0d", i), 1, MODE_SHL, 8'h00, 8'h00, 0,
              8'(8'hFF << (i + 1)), 1, 1);
      step("hold0", 1, MODE_HOLD, 8'h00, 8'h00, 0, 8'h00, 1, 0);
      step("ror0", 1, MODE_ROR, 8'h00, 8'h00, 0, 8'h00, 0, 0);
      step("load07", 1, MODE_LOAD, 8'h07, 8'h00, 0, 8'h07, 0, 1);
      step("load0f", 1, MODE_LOAD, 8'h0F, 8'h00, 0, 8'h0F, 0, 1);
      step("shr_a", 1, MODE_SHR, 8'h00, 8'h00, 0, 8'h07, 1, 1);
      drain();

      // reset in the middle of a shift run, between clock edges
      @(negedge clk);
      en = 1'b1;
      mode = MODE_SHR;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.q", 32'(q), 32'(RV));
      chk("midrst.ser_out", 32'(ser_out), 32'd0);
      chk("midrst.zero", 32'(zero), 32'd0);
      chk("midrst.changed", 32'(changed), 32'd0);
      @(negedge clk);
      chk("midrst_hold.q", 32'(q), 32'(RV));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
